// File: rtl/nsc8_pkg.sv
// Shared NSC-8 datapath definitions: the default data width and the all-zero bus value.
package nsc8_pkg;

  localparam int DATA_W = 8;
  localparam int MAX_W  = 64;

  // Held at the widest legal width so that any instance can slice out its own width.
  localparam logic [MAX_W-1:0] ALL_ZERO = '0;

endpackage

// File: rtl/accumulator_bus_driver.sv
// bus_driver: drives a register value onto the data bus when enabled. Zero when idle by default;
// high-Z when idle if ACCUMULATOR_TRISTATE_EN is defined.
module bus_driver
  import nsc8_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic [W-1:0] value,
  input  logic         enable,
  output logic [W-1:0] bus
);

`ifdef ACCUMULATOR_TRISTATE_EN
  assign bus = enable ? value : {W{1'bz}};
`else
  // The idle value is zero, so several drivers can share the bus through an OR.
  assign bus = enable ? value : ALL_ZERO[W-1:0];
`endif

endmodule

// File: rtl/accumulator.sv
// accumulator: register A of the NSC-8 datapath with zero/negative flags and a gated bus view.
// Define ACCUMULATOR_TRISTATE_EN to make data_out go high-Z instead of zero when output is disabled.
module accumulator
  import nsc8_pkg::*;
#(
  parameter int X = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [X-1:0] data_in,
  input  logic         load_a,
  input  logic         load_immediate_a,
  input  logic         output_enable,
  output logic [X-1:0] data_out,
  output logic [X-1:0] a_value,
  output logic         zero,
  output logic         negative
);

  logic [X-1:0] a_reg;
  logic         load;

  // Bus and immediate loads share one source, so asserting both together is legal.
  assign load = load_a | load_immediate_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= ALL_ZERO[X-1:0];
    end else if (load) begin
      a_reg <= data_in;
    end
  end

  assign a_value  = a_reg;
  assign zero     = (a_reg == ALL_ZERO[X-1:0]);
  assign negative = a_reg[X-1];

  // Driven from the register only; data_in has no combinational path to the bus.
  bus_driver #(
    .W (X)
  ) u_bus_driver (
    .value  (a_reg),
    .enable (output_enable),
    .bus    (data_out)
  );

endmodule

// File: tb/tb_accumulator.sv
// Self-checking bench for accumulator: an 8-bit instance driven by a scoreboard plus a 4-bit instance.
module tb_accumulator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       load_a, load_immediate_a, output_enable;
  logic [7:0] data_out, a_value;
  logic       zero, negative;

  logic [3:0] d4_in, d4_out, d4_a;
  logic       d4_load, d4_oe, d4_zero, d4_neg;

  int total = 0;
  int bad   = 0;

`ifdef ACCUMULATOR_TRISTATE_EN
  localparam logic [7:0] OFF8 = 8'bzzzz_zzzz;
`else
  localparam logic [7:0] OFF8 = 8'h00;
`endif

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] dout;
    logic       z;
    logic       n;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  accumulator #(.X(8)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (data_in),
    .load_a           (load_a),
    .load_immediate_a (load_immediate_a),
    .output_enable    (output_enable),
    .data_out         (data_out),
    .a_value          (a_value),
    .zero             (zero),
    .negative         (negative)
  );

  accumulator #(.X(4)) dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .data_in          (d4_in),
    .load_a           (d4_load),
    .load_immediate_a (1'b0),
    .output_enable    (d4_oe),
    .data_out         (d4_out),
    .a_value          (d4_a),
    .zero             (d4_zero),
    .negative         (d4_neg)
  );

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_now(input string tag, input logic [7:0] a, input logic [7:0] dout,
                            input logic z, input logic n);
    exp_t e;
    e.tag = tag; e.a = a; e.dout = dout; e.z = z; e.n = n;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".a_value"},  a_value,         e.a);
      cmp({e.tag, ".data_out"}, data_out,        e.dout);
      cmp({e.tag, ".zero"},     {7'd0, zero},     {7'd0, e.z});
      cmp({e.tag, ".negative"}, {7'd0, negative}, {7'd0, e.n});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic la, input logic li, input logic oe);
    data_in = d; load_a = la; load_immediate_a = li; output_enable = oe;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'hA5, 1'b1, 1'b0, 1'b0);
    d4_in = 4'h0; d4_load = 1'b0; d4_oe = 1'b1;

    // Reset with output disabled: A cleared, loads ignored, bus idle.
    #2;
    expect_now("reset_idle", 8'h00, OFF8, 1'b1, 1'b0);
    check_next();
    tick();
    expect_now("reset_held", 8'h00, OFF8, 1'b1, 1'b0);
    check_next();
    cmp("w4_reset.a_value", {4'd0, d4_a}, 8'h00);
    cmp("w4_reset.zero", {7'd0, d4_zero}, 8'h01);

    // Release at a falling edge; the first following rising edge loads.
    @(negedge clk);
    rst_n = 1'b1;
    drive(8'h5A, 1'b1, 1'b0, 1'b1);
    expect_now("load_5a", 8'h5A, 8'h5A, 1'b0, 1'b0);
    tick();
    check_next();

    // Mid-cycle reset takes effect without a clock edge.
    drive(8'h5A, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    expect_now("async_reset", 8'h00, 8'h00, 1'b1, 1'b0);
    check_next();
    @(negedge clk);
    rst_n = 1'b1;

    // Bus load with output enabled; 4-bit instance loads all ones alongside.
    drive(8'hFF, 1'b1, 1'b0, 1'b1);
    d4_in = 4'hF; d4_load = 1'b1;
    expect_now("bus_load_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick();
    check_next();
    d4_load = 1'b0;
    cmp("w4_load.a_value",  {4'd0, d4_a},   8'h0F);
    cmp("w4_load.data_out", {4'd0, d4_out}, 8'h0F);
    cmp("w4_load.negative", {7'd0, d4_neg}, 8'h01);
    cmp("w4_load.zero",     {7'd0, d4_zero}, 8'h00);

    // Immediate load, then hold while data_in changes.
    drive(8'hFF, 1'b0, 1'b1, 1'b1);
    expect_now("imm_load_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick();
    check_next();
    drive(8'h12, 1'b0, 1'b0, 1'b1);
    expect_now("hold_ff", 8'hFF, 8'hFF, 1'b0, 1'b1);
    tick();
    check_next();

    // Load with output disabled.
    drive(8'h8F, 1'b1, 1'b0, 1'b0);
    expect_now("load_oe_off", 8'h8F, OFF8, 1'b0, 1'b1);
    tick();
    check_next();

    // Output enable is combinational from A.
    output_enable = 1'b1;
    load_a = 1'b0;
    #1;
    expect_now("oe_on_comb", 8'h8F, 8'h8F, 1'b0, 1'b1);
    check_next();

    // Both strobes together with a zero operand.
    drive(8'h00, 1'b1, 1'b1, 1'b1);
    expect_now("both_load_zero", 8'h00, 8'h00, 1'b1, 1'b0);
    tick();
    check_next();
    drive(8'h01, 1'b1, 1'b0, 1'b1);
    expect_now("load_01", 8'h01, 8'h01, 1'b0, 1'b0);
    tick();
    check_next();

    // Pending load must not reach data_out before the edge.
    drive(8'h7E, 1'b0, 1'b1, 1'b1);
    #2;
    expect_now("pre_edge_old", 8'h01, 8'h01, 1'b0, 1'b0);
    check_next();
    expect_now("imm_load_7e", 8'h7E, 8'h7E, 1'b0, 1'b0);
    tick();
    check_next();

    // Glitches on data_in between edges with no strobe have no effect.
    drive(8'hC3, 1'b0, 1'b0, 1'b1);
    #1 data_in = 8'h3C;
    #1 data_in = 8'h99;
    expect_now("glitch_hold", 8'h7E, 8'h7E, 1'b0, 1'b0);
    tick();
    check_next();

    // Reset with output disabled after data is loaded.
    output_enable = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    expect_now("reset_oe_off", 8'h00, OFF8, 1'b1, 1'b0);
    check_next();
    rst_n = 1'b1;

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
